speed_ctrl: RTL and testbench
=============================

# speed_ctrl

Front-panel controller for the adjustable counter's 3-bit `set_speed` selector. It debounces three push-buttons (up, down, mode) and maintains the current speed code. In manual mode the code steps up or down on button presses; in auto mode it ping-pongs through the codes on a dwell timer. It sits between the board buttons and the counter's `set_speed_i`, one clock domain at 100 MHz.

## Interface
- `DEB_CYCLES`, default 1_000_000: required stable cycles for a debounced edge (10 ms).
- `DWELL_CYCLES`, default 500_000_000: cycles per step in auto mode (5 s).
- `MAX_SPEED`, default 5: highest legal speed code (legal range 0..MAX_SPEED, must be ≤ 7).
- `INIT_SPEED`, default 1: speed code after reset.
- `clk_i`, in, 1: system clock, 100 MHz.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `btn_up_i`, in, 1: raw button, asynchronous, active-high.
- `btn_down_i`, in, 1: raw button, asynchronous, active-high.
- `btn_mode_i`, in, 1: raw button, asynchronous, active-high.
- `set_speed_o`, out, 3: speed code driven to the counter.
- `auto_o`, out, 1: 1 while in auto mode.
- `speed_upd_o`, out, 1: one-cycle pulse in the cycle `set_speed_o` takes a new value.

## Operation
- Each button passes through a 2-flop synchroniser, then a debouncer.
- Debounced level flips once the synchronised input has differed from it for DEB_CYCLES consecutive cycles. Any reversal clears the count.
- Press pulse: asserted for 1 cycle when the debounced level goes 0→1. Releases produce no event.
- FSM states: MANUAL, AUTO_UP, AUTO_DOWN.
- MANUAL:
  - Up press: speed+1, saturating at MAX_SPEED.
  - Down press: speed−1, saturating at 0.
  - Up and down pressed in the same cycle: no change.
  - A saturated press gives no `speed_upd_o`.
- Mode press in MANUAL: go to AUTO_UP and clear the dwell timer.
- Mode press in AUTO_UP or AUTO_DOWN: go to MANUAL and hold the current speed.
- In auto states, up/down presses are ignored.
- AUTO_UP, on dwell expiry (timer = DWELL_CYCLES−1):
  - If speed < MAX_SPEED: speed+1.
  - Otherwise: go to AUTO_DOWN and apply speed−1.
  - Timer clears in both cases.
- AUTO_DOWN, on dwell expiry:
  - If speed > 0: speed−1.
  - Otherwise: go to AUTO_UP and apply speed+1.
- Mode press and dwell expiry in the same cycle: mode wins, no step.
- Speed codes MAX_SPEED+1..7 are never produced.

## Timing
- Reset values:
  - `set_speed_o` = INIT_SPEED, `auto_o` = 0, `speed_upd_o` = 0.
  - State = MANUAL; dwell timer, debounce counters and debounced levels = 0.
- Reset mid-operation drops any in-flight debounce or dwell progress. A button still held when reset is released yields one press after DEB_CYCLES+2 cycles.
- Press latency: raw input first sampled high at edge 0 → press pulse high after edge DEB_CYCLES+2 → `set_speed_o` and `speed_upd_o` change at edge DEB_CYCLES+3.
- Auto step period: exactly DWELL_CYCLES cycles between consecutive `speed_upd_o` pulses.
- First auto step: DWELL_CYCLES cycles after the mode-press cycle.
- `auto_o` is registered and changes in the same cycle as the state.

## Configuration
- `SPEED_CTRL_AUTO_EN` defined:
  - Auto states, dwell timer and mode-button debouncer are built.
  - Behaviour is as above.
- `SPEED_CTRL_AUTO_EN` undefined:
  - FSM is MANUAL only.
  - `btn_mode_i` is ignored and its debouncer is not instantiated.
  - `auto_o` is tied 0; DWELL_CYCLES is unused.

## Structure
- `speed_ctrl_pkg` contains:
  - `SPEED_W` = 3.
  - The `speed_state_t` enum (MANUAL, AUTO_UP, AUTO_DOWN).
  - Named speed code constants SPD_2S..SPD_57MS (codes 0..5).
- Sub-module `btn_debounce`: synchroniser, stable counter, debounced level and press pulse.
  - Parameter: DEB_CYCLES.
  - Ports: `clk_i`, `rst_i`, `btn_i`, `level_o`, `press_o`.
  - Instantiated once per button.

## Test plan
All scenarios use DEB_CYCLES=4, DWELL_CYCLES=8, MAX_SPEED=5, INIT_SPEED=1.

- **Reset and up press:** reset, then hold `btn_up_i` for 10 cycles → `set_speed_o` 1→2 at edge 7 after the press, with one `speed_upd_o` pulse. Glitch up for 3 cycles → no change.
- **Manual saturation:** 6 up presses → stops at 5, with only 4 `speed_upd_o` pulses. 7 down presses from 5 → stops at 0. Simultaneous up+down → no change, no pulse.
- **Auto ping-pong:** mode press at speed 4 → `auto_o`=1. Sequence 5, 4, 3, 2, 1, 0, 1, ... with a step every 8 cycles.
- **Auto exit and conflict:** mode press coinciding with dwell expiry → MANUAL, speed unchanged, no pulse. Up presses during auto → ignored.
- **Reset mid-operation:** assert `rst_i` mid-debounce and mid-dwell → outputs return to 1/0/0 on the next edge. Button held through reset → one press 6 edges after release.
- **`SPEED_CTRL_AUTO_EN` undefined:** mode presses → `auto_o` stays 0 and speed is unchanged.

Source files
------------

// File: rtl/speed_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : speed_ctrl_pkg
// Purpose  : Shared types and constants for the front-panel speed controller.
//            Holds the speed-code width, the controller state encoding and
//            named speed codes matching the counter's set_speed selector.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package speed_ctrl_pkg;

  localparam int SPEED_W = 3;

  typedef enum logic [1:0] {
    MANUAL    = 2'd0,
    AUTO_UP   = 2'd1,
    AUTO_DOWN = 2'd2
  } speed_state_t;

  // Named codes understood by the adjustable counter (tick period per code).
  localparam logic [SPEED_W-1:0] SPD_2S    = 3'd0;
  localparam logic [SPEED_W-1:0] SPD_1S    = 3'd1;
  localparam logic [SPEED_W-1:0] SPD_500MS = 3'd2;
  localparam logic [SPEED_W-1:0] SPD_250MS = 3'd3;
  localparam logic [SPEED_W-1:0] SPD_115MS = 3'd4;
  localparam logic [SPEED_W-1:0] SPD_57MS  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/speed_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : Synchronises one raw push-button into clk_i, debounces it with a
//            stable-cycle counter and emits a one-cycle press pulse on each
//            debounced 0->1 transition.
// Ports    : clk_i   - system clock
//            rst_i   - synchronous active-high reset
//            btn_i   - raw asynchronous button level
//            level_o - debounced button level
//            press_o - one-cycle pulse per debounced press
// Params   : DEB_CYCLES - consecutive differing cycles needed to flip level
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             level_prev_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count cycles where the synchronised input disagrees with the debounced
  // level; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      level_prev_q <= level_q;
      // Registered rising-edge detect of the debounced level.
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/speed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : speed_ctrl
// Purpose  : Front-panel controller for the counter's 3-bit speed selector.
//            Debounces up/down/mode buttons and keeps the current speed code.
//            Manual mode steps the code on presses (saturating); auto mode
//            ping-pongs through 0..MAX_SPEED on a dwell timer.
// Ports    : clk_i       - 100 MHz system clock
//            rst_i       - synchronous active-high reset
//            btn_up_i    - raw up button
//            btn_down_i  - raw down button
//            btn_mode_i  - raw mode button (ignored without auto feature)
//            set_speed_o - speed code to the counter
//            auto_o      - high while in auto mode
//            speed_upd_o - one-cycle pulse when set_speed_o changes
// Config   : SPEED_CTRL_AUTO_EN - when defined, builds the auto states, dwell
//            timer and mode-button debouncer; otherwise manual only.
// Revision : 1.0 - initial release
// ============================================================================
module speed_ctrl
  import speed_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = 1_000_000,
  parameter int unsigned DWELL_CYCLES = 500_000_000,
  parameter int unsigned MAX_SPEED    = 5,
  parameter int unsigned INIT_SPEED   = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               btn_up_i,
  input  logic               btn_down_i,
  input  logic               btn_mode_i,
  output logic [SPEED_W-1:0] set_speed_o,
  output logic               auto_o,
  output logic               speed_upd_o
);

  localparam logic [SPEED_W-1:0] MAX_CODE  = SPEED_W'(MAX_SPEED);
  localparam logic [SPEED_W-1:0] INIT_CODE = SPEED_W'(INIT_SPEED);

  logic up_press_w;
  logic down_press_w;
  logic up_level_unused;
  logic down_level_unused;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_i   (btn_up_i),
    .level_o (up_level_unused),
    .press_o (up_press_w)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_i   (btn_down_i),
    .level_o (down_level_unused),
    .press_o (down_press_w)
  );

`ifdef SPEED_CTRL_AUTO_EN
  localparam int unsigned DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  logic               mode_press_w;
  logic               mode_level_unused;
  logic               auto_q;
  logic [DWELL_W-1:0] dwell_q;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_i   (btn_mode_i),
    .level_o (mode_level_unused),
    .press_o (mode_press_w)
  );
`else
  logic unused_mode_w;
  assign unused_mode_w = btn_mode_i | (DWELL_CYCLES == 0);
`endif

  speed_state_t       state_q;
  logic [SPEED_W-1:0] speed_q;
  logic               upd_q;

  // Manual-mode step: opposing presses cancel, saturated presses are silent.
  logic [SPEED_W-1:0] step_speed_d;
  logic               step_upd_d;

  always_comb begin
    step_speed_d = speed_q;
    step_upd_d   = 1'b0;
    if (up_press_w && !down_press_w) begin
      if (speed_q < MAX_CODE) begin
        step_speed_d = speed_q + 1'b1;
        step_upd_d   = 1'b1;
      end
    end else if (down_press_w && !up_press_w) begin
      if (speed_q != '0) begin
        step_speed_d = speed_q - 1'b1;
        step_upd_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MANUAL;
      speed_q <= INIT_CODE;
      upd_q   <= 1'b0;
`ifdef SPEED_CTRL_AUTO_EN
      auto_q  <= 1'b0;
      dwell_q <= '0;
`endif
    end else begin
      upd_q <= 1'b0;
      unique case (state_q)
        MANUAL: begin
`ifdef SPEED_CTRL_AUTO_EN
          if (mode_press_w) begin
            state_q <= AUTO_UP;
            auto_q  <= 1'b1;
            dwell_q <= '0;
          end else
`endif
          begin
            speed_q <= step_speed_d;
            upd_q   <= step_upd_d;
          end
        end
`ifdef SPEED_CTRL_AUTO_EN
        AUTO_UP, AUTO_DOWN: begin
          // A mode press takes priority over a coincident dwell expiry.
          if (mode_press_w) begin
            state_q <= MANUAL;
            auto_q  <= 1'b0;
            dwell_q <= '0;
          end else if (dwell_q == DWELL_LAST) begin
            dwell_q <= '0;
            upd_q   <= 1'b1;
            if (state_q == AUTO_UP) begin
              if (speed_q < MAX_CODE) begin
                speed_q <= speed_q + 1'b1;
              end else begin
                state_q <= AUTO_DOWN;
                speed_q <= speed_q - 1'b1;
              end
            end else begin
              if (speed_q != '0) begin
                speed_q <= speed_q - 1'b1;
              end else begin
                state_q <= AUTO_UP;
                speed_q <= speed_q + 1'b1;
              end
            end
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
`endif
        default: begin
          state_q <= MANUAL;
`ifdef SPEED_CTRL_AUTO_EN
          auto_q  <= 1'b0;
          dwell_q <= '0;
`endif
        end
      endcase
    end
  end

  assign set_speed_o = speed_q;
  assign speed_upd_o = upd_q;
`ifdef SPEED_CTRL_AUTO_EN
  assign auto_o      = auto_q;
`else
  assign auto_o      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_speed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_speed_ctrl
// Purpose  : Self-checking bench for speed_ctrl. Stimulus pushes expected
//            speed-update events (edge number, new code) into a queue; a
//            monitor pops one per speed_upd_o pulse and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_speed_ctrl;

  localparam int DEB   = 4;
  localparam int DWELL = 8;
  localparam int MAXS  = 5;
  localparam int INIT  = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_mode = 1'b0;
  logic [2:0] set_speed;
  logic       auto_w;
  logic       upd;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int model_sp = INIT;

  typedef struct {
    int ecyc;
    int espd;
  } ev_t;

  ev_t        exp_q[$];
  logic [2:0] prev_speed;

  speed_ctrl #(
    .DEB_CYCLES   (DEB),
    .DWELL_CYCLES (DWELL),
    .MAX_SPEED    (MAXS),
    .INIT_SPEED   (INIT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .btn_up_i    (btn_up),
    .btn_down_i  (btn_down),
    .btn_mode_i  (btn_mode),
    .set_speed_o (set_speed),
    .auto_o      (auto_w),
    .speed_upd_o (upd)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse must match the oldest expected event; the code may
  // never change without a pulse.
  always @(posedge clk) begin
    ev_t e;
    #1;
    if (rst) begin
      prev_speed = set_speed;
    end else begin
      if (upd) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL upd_unexpected: pulse at cycle %0d speed %0d, none expected", cyc, set_speed);
        end else begin
          e = exp_q.pop_front();
          if (e.ecyc != cyc || e.espd != int'(set_speed)) begin
            bad++;
            $display("FAIL upd_event: got cycle %0d speed %0d, expected cycle %0d speed %0d",
                     cyc, set_speed, e.ecyc, e.espd);
          end
        end
      end else if (set_speed != prev_speed) begin
        total++;
        bad++;
        $display("FAIL change_without_pulse: speed %0d->%0d at cycle %0d", prev_speed, set_speed, cyc);
      end
      prev_speed = set_speed;
    end
  end

  task automatic check(input string name, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  task automatic push_ev(input int c, input int s);
    ev_t e;
    e.ecyc = c;
    e.espd = s;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs();
    check("reset_speed", int'(set_speed), INIT);
    check("reset_auto", int'(auto_w), 0);
    check("reset_upd", int'(upd), 0);
  endtask

  // kind: 0 up, 1 down, 2 up+down, 3 up only (glitch length), 4 down only.
  task automatic manual(input int kind, input int hold, input int gap);
    int e0;
    @(negedge clk);
    e0       = cyc + 1;
    btn_up   = (kind == 0 || kind == 2 || kind == 3);
    btn_down = (kind == 1 || kind == 2 || kind == 4);
    if (hold >= DEB) begin
      if (btn_up && !btn_down && model_sp < MAXS) begin
        model_sp++;
        push_ev(e0 + DEB + 3, model_sp);
      end else if (btn_down && !btn_up && model_sp > 0) begin
        model_sp--;
        push_ev(e0 + DEB + 3, model_sp);
      end
    end
    repeat (hold) @(negedge clk);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (gap) @(negedge clk);
    check("speed_after_action", int'(set_speed), model_sp);
  endtask

  task automatic mode_enter(output int em);
    int e0;
    @(negedge clk);
    e0       = cyc + 1;
    em       = e0 + DEB + 3;
    btn_mode = 1'b1;
    repeat (DEB + 2) @(negedge clk);
    btn_mode = 1'b0;
    while (cyc < em - 1) @(negedge clk);
    check("auto_before_entry", int'(auto_w), 0);
    @(negedge clk);
`ifdef SPEED_CTRL_AUTO_EN
    check("auto_after_entry", int'(auto_w), 1);
`else
    check("auto_stays_low", int'(auto_w), 0);
`endif
    check("speed_at_entry", int'(set_speed), model_sp);
  endtask

`ifdef SPEED_CTRL_AUTO_EN
  // Auto segment of nsteps dwell periods; with conflict the exit press lands
  // exactly on the last expiry, which must then not step.
  task automatic auto_segment(input int nsteps, input bit conflict);
    int em;
    int ex;
    int sp;
    bit going_up;
    mode_enter(em);
    ex = em + nsteps * DWELL + (conflict ? 0 : int'($urandom_range(1, DWELL - 1)));
    sp = model_sp;
    going_up = 1'b1;
    for (int k = 1; em + k * DWELL < ex; k++) begin
      if (going_up) begin
        if (sp < MAXS) sp++;
        else begin going_up = 1'b0; sp--; end
      end else begin
        if (sp > 0) sp--;
        else begin going_up = 1'b1; sp++; end
      end
      push_ev(em + k * DWELL, sp);
    end
    model_sp = sp;
    // An up press while in auto must be ignored.
    @(negedge clk);
    btn_up = 1'b1;
    repeat (DEB + 2) @(negedge clk);
    btn_up = 1'b0;
    while (cyc < ex - DEB - 4) @(negedge clk);
    btn_mode = 1'b1;
    repeat (DEB + 2) @(negedge clk);
    btn_mode = 1'b0;
    while (cyc < ex) @(negedge clk);
    check("auto_after_exit", int'(auto_w), 0);
    check("speed_at_exit", int'(set_speed), model_sp);
    repeat (DEB + 4) @(negedge clk);
  endtask
`endif

  initial begin
    int em;
    int e0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    model_sp = INIT;

    // First press and a too-short glitch, then the exact-length boundary.
    manual(0, 10, DEB + 4);
    manual(3, DEB - 1, DEB + 4);
    manual(4, DEB - 1, DEB + 4);
    manual(1, DEB, DEB + 4);

    // Saturation at both ends, then opposing presses.
    repeat (6) manual(0, DEB + 2, DEB + 4);
    check("saturated_top", int'(set_speed), MAXS);
    repeat (7) manual(1, DEB + 2, DEB + 4);
    check("saturated_bottom", int'(set_speed), 0);
    manual(0, DEB + 2, DEB + 4);
    manual(2, DEB + 2, DEB + 4);

    // Randomised manual traffic.
    for (int i = 0; i < 40; i++) begin
      int kind;
      int hold;
      kind = int'($urandom_range(0, 4));
      hold = (kind >= 3) ? int'($urandom_range(1, DEB - 1)) : int'($urandom_range(DEB, DEB + 4));
      manual(kind, hold, int'($urandom_range(DEB + 3, DEB + 6)));
    end

    // Reset mid-debounce with the button held through reset.
    @(negedge clk);
    btn_up = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    e0 = cyc + 1;
    model_sp = INIT + 1;
    push_ev(e0 + DEB + 3, model_sp);
    repeat (DEB + 4) @(negedge clk);
    btn_up = 1'b0;
    repeat (DEB + 4) @(negedge clk);
    check("speed_after_held_reset", int'(set_speed), model_sp);

    while (model_sp < 4) manual(0, DEB + 2, DEB + 4);
    while (model_sp > 4) manual(1, DEB + 2, DEB + 4);

`ifdef SPEED_CTRL_AUTO_EN
    auto_segment(9, 1'b0);
    auto_segment(4, 1'b1);
    auto_segment(int'($urandom_range(3, 12)), 1'(($urandom_range(0, 1))));
    manual(0, DEB + 2, DEB + 4);
    // Reset mid-dwell: no further steps may follow.
    mode_enter(em);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    model_sp = INIT;
    repeat (2 * DWELL + 4) @(negedge clk);
    check("speed_after_dwell_reset", int'(set_speed), INIT);
    check("auto_after_dwell_reset", int'(auto_w), 0);
`else
    mode_enter(em);
    repeat (DEB + 4) @(negedge clk);
    mode_enter(em);
    repeat (2 * DWELL) @(negedge clk);
    check("speed_mode_ignored", int'(set_speed), model_sp);
    manual(1, DEB + 2, DEB + 4);
`endif

    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: cycle %0d reached time limit", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
